// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 16-bit log shifter; the result sits in a
// one-entry output buffer and is returned with the winning requester's id.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_valid/ready          request handshake (ready is combinational from valid)
//   req{0,1}_data/amnt/op         operand, shift amount 0..15, op 00 ROL 01 SLL 10 ROR 11 SRL
//   out_valid/out_ready           result buffer handshake
//   out_data, out_id              shifted result and the requester that produced it
module shift_arbiter #(
  parameter bit FAIR_RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic [3:0]  req0_amnt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req1_amnt,
  input  logic [1:0]  req1_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_id
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned OW = 2;

  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic          r_out_id;
  logic          r_last_grant;

  logic          w_accept;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_xfer0;
  logic          w_xfer1;
  logic [DW-1:0] w_sel_data;
  logic [AW-1:0] w_sel_amnt;
  logic [OW-1:0] w_sel_op;
  logic          w_right;
  logic          w_zero_fill;
  logic [DW-1:0] w_shift_in;
  logic [DW-1:0] w_stage [0:AW];
  logic [DW-1:0] w_result;

  function automatic logic [DW-1:0] bit_rev(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DW); i++) begin
      r[i] = d[DW-1-i];
    end
    return r;
  endfunction

  // Buffer can take a new result when empty or when it drains this cycle.
  assign w_accept = !r_out_valid || out_ready;

  // Arbitration: with both valid, round-robin favours the requester that did not win last.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FAIR_RR) begin
        w_grant0 = r_last_grant;
        w_grant1 = !r_last_grant;
      end else begin
        w_grant0 = 1'b1;
      end
    end else begin
      w_grant0 = req0_valid;
      w_grant1 = req1_valid;
    end
  end

  assign req0_ready = w_grant0 && w_accept && !rst;
  assign req1_ready = w_grant1 && w_accept && !rst;

  assign w_xfer0 = req0_valid && req0_ready;
  assign w_xfer1 = req1_valid && req1_ready;

  // Operand mux follows the grant; un-granted requests are never latched.
  always_comb begin
    w_sel_data = req0_data;
    w_sel_amnt = req0_amnt;
    w_sel_op   = req0_op;
    if (w_grant1) begin
      w_sel_data = req1_data;
      w_sel_amnt = req1_amnt;
      w_sel_op   = req1_op;
    end
  end

  // op[1] selects right direction, op[0] selects zero-fill instead of rotate.
  // Right ops run through the left shifter between two bit reversals.
  assign w_right     = w_sel_op[1];
  assign w_zero_fill = w_sel_op[0];
  assign w_shift_in  = w_right ? bit_rev(w_sel_data) : w_sel_data;
  assign w_stage[0]  = w_shift_in;

  for (genvar k = 0; k < int'(AW); k++) begin : g_stage
    localparam int unsigned SH = 1 << k;
    logic [SH-1:0] w_wrap;
    // Bits leaving the top re-enter at the bottom for rotates, zeros for shifts.
    assign w_wrap = w_zero_fill ? '0 : w_stage[k][DW-1 -: SH];
    assign w_stage[k+1] = w_sel_amnt[k] ? {w_stage[k][DW-1-SH:0], w_wrap} : w_stage[k];
  end

  assign w_result = w_right ? bit_rev(w_stage[AW]) : w_stage[AW];

  // Output buffer and last-grant tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_id     <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_xfer0 || w_xfer1) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_result;
      r_out_id     <= w_xfer1;
      r_last_grant <= w_xfer1;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level reference model.
module tb_shift_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_amnt, req1_amnt;
  logic [1:0]  req0_op, req1_op;
  logic        out_valid, out_ready, out_id;
  logic [15:0] out_data;

  // Fixed-priority instance, exercised only in the arbitration scenario.
  logic        fp0_valid, fp0_ready, fp1_valid, fp1_ready;
  logic [15:0] fp0_data, fp1_data, fp_out_data;
  logic [3:0]  fp0_amnt, fp1_amnt;
  logic [1:0]  fp0_op, fp1_op;
  logic        fp_out_valid, fp_out_ready, fp_out_id;

  shift_arbiter #(.FAIR_RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amnt(req0_amnt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amnt(req1_amnt), .req1_op(req1_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );

  shift_arbiter #(.FAIR_RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(fp0_valid), .req0_ready(fp0_ready), .req0_data(fp0_data),
    .req0_amnt(fp0_amnt), .req0_op(fp0_op),
    .req1_valid(fp1_valid), .req1_ready(fp1_ready), .req1_data(fp1_data),
    .req1_amnt(fp1_amnt), .req1_op(fp1_op),
    .out_valid(fp_out_valid), .out_ready(fp_out_ready), .out_data(fp_out_data),
    .out_id(fp_out_id)
  );

  localparam logic [1:0] ROL = 2'b00, SLL = 2'b01, ROR = 2'b10, SRL = 2'b11;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_id;
  logic        m_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Rotations via a doubled word, shifts via a widened word.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a,
                                            input logic [1:0] op);
    logic [31:0] t;
    case (op)
      ROL:     t = ({d, d} << a) >> 16;
      SLL:     t = {16'h0000, d} << a;
      ROR:     t = {d, d} >> a;
      default: t = {16'h0000, d} >> a;
    endcase
    return t[15:0];
  endfunction

  // One clock: check readies against the model, advance model, check outputs.
  task automatic step(output logic g0, output logic g1);
    logic        acc, e0, e1, nv, ni, nl;
    logic [15:0] nd;
    #1;
    acc = !m_valid || out_ready;
    if (req0_valid && req1_valid) begin
      e0 = m_last;
      e1 = !m_last;
    end else begin
      e0 = req0_valid;
      e1 = req1_valid;
    end
    e0 = e0 && acc && !rst;
    e1 = e1 && acc && !rst;
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    nv = m_valid; nd = m_data; ni = m_id; nl = m_last;
    if (rst) begin
      nv = 1'b0; nd = 16'h0000; ni = 1'b0; nl = 1'b1;
    end else if (e0) begin
      nv = 1'b1; nd = ref_shift(req0_data, req0_amnt, req0_op); ni = 1'b0; nl = 1'b0;
    end else if (e1) begin
      nv = 1'b1; nd = ref_shift(req1_data, req1_amnt, req1_op); ni = 1'b1; nl = 1'b1;
    end else if (out_ready) begin
      nv = 1'b0;
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_data = nd; m_id = ni; m_last = nl;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_id", 32'(out_id), 32'(m_id));
    g0 = e0;
    g1 = e1;
  endtask

  task automatic set_req0(input logic v, input logic [15:0] d, input logic [3:0] a,
                          input logic [1:0] op);
    req0_valid = v; req0_data = d; req0_amnt = a; req0_op = op;
  endtask

  task automatic set_req1(input logic v, input logic [15:0] d, input logic [3:0] a,
                          input logic [1:0] op);
    req1_valid = v; req1_data = d; req1_amnt = a; req1_op = op;
  endtask

  initial begin
    logic        g0, g1, p0, p1;
    logic [15:0] edge_d [4];
    logic [3:0]  edge_a [4];
    logic [1:0]  edge_o [4];
    logic [15:0] edge_e [4];

    m_valid = 1'b0; m_data = 16'h0000; m_id = 1'b0; m_last = 1'b1;
    rst = 1'b1; out_ready = 1'b1;
    set_req0(1'b0, 16'h0, 4'h0, ROL);
    set_req1(1'b0, 16'h0, 4'h0, ROL);
    fp0_valid = 1'b0; fp0_data = 16'h1234; fp0_amnt = 4'd4; fp0_op = ROL;
    fp1_valid = 1'b0; fp1_data = 16'h1234; fp1_amnt = 4'd4; fp1_op = ROR;
    fp_out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset held two cycles with req0 asking.
    set_req0(1'b1, 16'h8001, 4'd1, ROL);
    for (int i = 0; i < 2; i++) begin
      step(g0, g1);
      chk("rst_ready0", 32'(g0), 32'd0);
    end
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0000);

    // Single requester traffic.
    rst = 1'b0;
    step(g0, g1);
    chk("first_grant0", 32'(g0), 32'd1);
    chk("rol_8001", 32'(out_data), 32'h0003);
    set_req0(1'b0, 16'h0, 4'h0, ROL);
    set_req1(1'b1, 16'h8001, 4'd1, ROR);
    step(g0, g1);
    chk("ror_8001", 32'(out_data), 32'hC000);
    chk("ror_8001_id", 32'(out_id), 32'd1);

    // Both valid continuously: alternating results; fixed-priority copy stays on id0.
    set_req0(1'b1, 16'h1234, 4'd4, ROL);
    set_req1(1'b1, 16'h1234, 4'd4, ROR);
    fp0_valid = 1'b1; fp1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(g0, g1);
      chk("rr_data", 32'(out_data), (k % 2 == 0) ? 32'h2341 : 32'h4123);
      chk("rr_id", 32'(out_id), 32'(k % 2));
      chk("fp_valid", 32'(fp_out_valid), 32'd1);
      chk("fp_data", 32'(fp_out_data), 32'h2341);
      chk("fp_id", 32'(fp_out_id), 32'd0);
    end
    fp0_valid = 1'b0; fp1_valid = 1'b0;
    set_req1(1'b0, 16'h0, 4'h0, ROL);

    // Shift boundary cases.
    edge_d[0] = 16'h000F; edge_a[0] = 4'd12; edge_o[0] = SLL; edge_e[0] = 16'hF000;
    edge_d[1] = 16'hF000; edge_a[1] = 4'd15; edge_o[1] = SRL; edge_e[1] = 16'h0001;
    edge_d[2] = 16'hA5C3; edge_a[2] = 4'd0;  edge_o[2] = ROL; edge_e[2] = 16'hA5C3;
    edge_d[3] = 16'h0001; edge_a[3] = 4'd15; edge_o[3] = ROR; edge_e[3] = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      set_req0(1'b1, edge_d[k], edge_a[k], edge_o[k]);
      step(g0, g1);
      chk("edge_shift", 32'(out_data), 32'(edge_e[k]));
    end

    // Backpressure: result held, readies low, then drain+accept with no bubble.
    set_req0(1'b1, 16'h00FF, 4'd8, ROL);
    step(g0, g1);
    set_req0(1'b0, 16'h0, 4'h0, ROL);
    set_req1(1'b1, 16'h0F0F, 4'd4, SRL);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(g0, g1);
      chk("bp_ready1", 32'(g1), 32'd0);
      chk("bp_hold", 32'(out_data), 32'hFF00);
    end
    out_ready = 1'b1;
    step(g0, g1);
    chk("bp_release_ready1", 32'(g1), 32'd1);
    chk("bp_new_valid", 32'(out_valid), 32'd1);
    chk("bp_new_data", 32'(out_data), 32'h00F0);

    // Reset with a pending result after a req1 win; req0 must win afterwards.
    set_req1(1'b1, 16'h0003, 4'd2, SLL);
    step(g0, g1);
    set_req1(1'b0, 16'h0, 4'h0, ROL);
    out_ready = 1'b0;
    step(g0, g1);
    rst = 1'b1;
    step(g0, g1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    set_req0(1'b1, 16'h0001, 4'd1, SLL);
    set_req1(1'b1, 16'h0001, 4'd1, ROR);
    step(g0, g1);
    chk("midrst_grant0", 32'(g0), 32'd1);
    chk("midrst_data", 32'(out_data), 32'h0002);
    set_req0(1'b0, 16'h0, 4'h0, ROL);
    set_req1(1'b0, 16'h0, 4'h0, ROL);

    // Randomized traffic with requesters honouring the hold-until-ready rule.
    p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!p0 && ($urandom % 3) != 0) begin
        p0 = 1'b1;
        set_req0(1'b1, 16'($urandom), 4'($urandom), 2'($urandom));
      end
      if (!p1 && ($urandom % 3) != 0) begin
        p1 = 1'b1;
        set_req1(1'b1, 16'($urandom), 4'($urandom), 2'($urandom));
      end
      req0_valid = p0;
      req1_valid = p1;
      out_ready  = ($urandom % 4) != 0;
      rst        = ($urandom % 64) == 0;
      step(g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
